// File: rtl/usr_shift_sequencer.sv
// usr_shift_sequencer
//   Command front end for a WIDTH-bit universal shift register. A word plus a
//   shift command arrives over a valid/ready handshake. The sequencer then
//   drives the register for one LOAD cycle, up to WIDTH shift cycles and one
//   DONE cycle.
//
// Configuration macro:
//   USR_SEQ_ROTATE_EN  defined   : the serial inputs are taken from usr_q, so
//                                  the word rotates and in_fill is ignored.
//                      undefined : both serial inputs carry the latched in_fill
//                                  bit during SHIFT.
//
// Ports:
//   clk        rising-edge clock
//   clr_n      asynchronous active-low reset; aborts any command in flight
//   in_valid   command valid
//   in_ready   command can be accepted (IDLE or DONE; also 1 in reset)
//   in_data    word to parallel-load
//   in_dir     0 = shift right (sel 01), 1 = shift left (sel 10)
//   in_cnt     number of shift cycles, clamped to WIDTH; 0 = load only
//   in_fill    serial fill bit (non-rotate build)
//   usr_q      shift register output, fed back for rotation
//   sel        00 hold, 01 right, 10 left, 11 parallel load (registered)
//   par_out    parallel input of the register (registered, holds when idle)
//   right_out  serial bit entering the MSB on a right shift (SHIFT only)
//   left_out   serial bit entering the LSB on a left shift (SHIFT only)
//   busy       LOAD or SHIFT in progress (registered)
//   done       one-cycle pulse while the register holds the result (registered)
module usr_shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  input  logic [CW-1:0]    in_cnt,
  input  logic             in_fill,
  input  logic [WIDTH-1:0] usr_q,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] par_out,
  output logic             right_out,
  output logic             left_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_LOAD  = 2'b01,
    S_SHIFT = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_RIGHT = 2'b01;
  localparam logic [1:0] SEL_LEFT  = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             dir_reg;
  logic [1:0]       sel_reg, sel_next;
  logic [WIDTH-1:0] par_reg;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  logic             accept;
  logic [CW-1:0]    cnt_clamped;

  // Ready is decoded straight from the state so a command can be taken in
  // the DONE cycle without an IDLE bubble.
  assign in_ready    = (state_reg == S_IDLE) || (state_reg == S_DONE);
  assign accept      = in_valid && in_ready;
  assign cnt_clamped = (in_cnt > CNT_MAX) ? CNT_MAX : in_cnt;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          state_next = S_LOAD;
          cnt_next   = cnt_clamped;
        end
      end
      S_LOAD: begin
        state_next = (cnt_reg == '0) ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        cnt_next = cnt_reg - CW'(1);
        // <= 1 rather than == 1 so a corrupted zero count can never wedge here
        if (cnt_reg <= CW'(1)) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (accept) begin
          state_next = S_LOAD;
          cnt_next   = cnt_clamped;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up
  // with the state they describe (accept edge -> sel=11 in the next cycle).
  // dir_reg is already valid whenever SHIFT can be the next state.
  always_comb begin
    sel_next  = SEL_HOLD;
    busy_next = 1'b0;
    done_next = 1'b0;
    case (state_next)
      S_LOAD: begin
        sel_next  = SEL_LOAD;
        busy_next = 1'b1;
      end
      S_SHIFT: begin
        sel_next  = dir_reg ? SEL_LEFT : SEL_RIGHT;
        busy_next = 1'b1;
      end
      S_DONE: begin
        done_next = 1'b1;
      end
      default: begin
        sel_next = SEL_HOLD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      dir_reg   <= 1'b0;
      sel_reg   <= SEL_HOLD;
      par_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      sel_reg   <= sel_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      if (accept) begin
        // par_out doubles as the latched data word and keeps it when idle
        dir_reg <= in_dir;
        par_reg <= in_data;
      end
    end
  end

  assign sel     = sel_reg;
  assign par_out = par_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;

`ifdef USR_SEQ_ROTATE_EN
  // Feed the outgoing bit back in at the opposite end.
  logic unused_fill;
  assign unused_fill = in_fill;

  always_comb begin
    right_out = 1'b0;
    left_out  = 1'b0;
    if (state_reg == S_SHIFT) begin
      right_out = usr_q[0];
      left_out  = usr_q[WIDTH-1];
    end
  end
`else
  logic fill_reg;
  logic unused_q;
  assign unused_q = ^usr_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      fill_reg <= 1'b0;
    end else if (accept) begin
      fill_reg <= in_fill;
    end
  end

  always_comb begin
    right_out = 1'b0;
    left_out  = 1'b0;
    if (state_reg == S_SHIFT) begin
      right_out = fill_reg;
      left_out  = fill_reg;
    end
  end
`endif

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Testbench for usr_shift_sequencer. A behavioural 4-bit universal shift
// register is driven by the sequencer outputs and feeds usr_q back. Each
// issued command pushes its reference final word (from ref_result) into a
// scoreboard queue; the entry is popped and compared when done pulses.
module tb_usr_shift_sequencer;

  localparam int WIDTH = 4;
  localparam int CW    = 3;

  logic             clk = 1'b0;
  logic             clr_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_dir;
  logic [CW-1:0]    in_cnt;
  logic             in_fill;
  logic [WIDTH-1:0] usr_q;
  logic [1:0]       sel;
  logic [WIDTH-1:0] par_out;
  logic             right_out;
  logic             left_out;
  logic             busy;
  logic             done;

  logic [WIDTH-1:0] shreg = '0;
  logic [WIDTH-1:0] exp_q[$];
  int               tests = 0;
  int               fails = 0;

  always #5 clk = ~clk;

  usr_shift_sequencer #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_dir   (in_dir),
    .in_cnt   (in_cnt),
    .in_fill  (in_fill),
    .usr_q    (usr_q),
    .sel      (sel),
    .par_out  (par_out),
    .right_out(right_out),
    .left_out (left_out),
    .busy     (busy),
    .done     (done)
  );

  // Universal shift register driven by the sequencer.
  assign usr_q = shreg;
  always @(posedge clk) begin
    case (sel)
      2'b11:   shreg <= par_out;
      2'b01:   shreg <= {right_out, shreg[WIDTH-1:1]};
      2'b10:   shreg <= {shreg[WIDTH-2:0], left_out};
      default: shreg <= shreg;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Reference result of a command, computed from the command alone.
  function automatic logic [WIDTH-1:0] ref_result(input logic [WIDTH-1:0] d, input logic dir,
                                                  input logic [CW-1:0] c, input logic fill);
    int n;
    logic [WIDTH-1:0] r;
    n = (int'(c) > WIDTH) ? WIDTH : int'(c);
    r = d;
    for (int i = 0; i < n; i++) begin
`ifdef USR_SEQ_ROTATE_EN
      r = dir ? {r[WIDTH-2:0], r[WIDTH-1]} : {r[0], r[WIDTH-1:1]};
`else
      r = dir ? {r[WIDTH-2:0], fill} : {fill, r[WIDTH-1:1]};
`endif
    end
    return r;
  endfunction

  // Present a command and return #1 after the accepting edge.
  task automatic issue(input logic [WIDTH-1:0] d, input logic dir, input logic [CW-1:0] c,
                       input logic fill);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_dir   = dir;
    in_cnt   = c;
    in_fill  = fill;
    exp_q.push_back(ref_result(d, dir, c, fill));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 4'($urandom);
    in_dir   = 1'($urandom);
    in_cnt   = 3'($urandom);
    in_fill  = 1'($urandom);
    $display("[TB] cmd data=%b dir=%0d cnt=%0d fill=%0d accepted", d, dir, c, fill);
  endtask

  // Follow a command from its LOAD cycle through DONE; ends #1 after the DONE edge.
  task automatic follow(input logic [WIDTH-1:0] d, input logic dir, input logic [CW-1:0] c,
                        input logic fill, input logic poke);
    int n;
    logic [WIDTH-1:0] want;
    n = (int'(c) > WIDTH) ? WIDTH : int'(c);
    check("load_sel", 32'(sel), 32'd3);
    check("load_par", 32'(par_out), 32'(d));
    check("load_busy", 32'(busy), 32'd1);
    check("load_ready", 32'(in_ready), 32'd0);
    if (poke) begin
      // a request while busy must be ignored
      in_valid = 1'b1;
      in_data  = ~d;
    end
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
`ifdef USR_SEQ_ROTATE_EN
        check("shift_serial", 32'(dir ? left_out : right_out), 32'(dir ? shreg[WIDTH-1] : shreg[0]));
`else
        if (i > 0) check("shift_serial", 32'(dir ? left_out : right_out), 32'(fill));
`endif
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (i < n) begin
        check("shift_sel", 32'(sel), dir ? 32'd2 : 32'd1);
        check("shift_done", 32'(done), 32'd0);
      end
    end
    check("done_sel", 32'(sel), 32'd0);
    check("done_pulse", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("done_ready", 32'(in_ready), 32'd1);
    check("done_par", 32'(par_out), 32'(d));
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
    end else begin
      want = exp_q.pop_front();
      check("result_word", 32'(shreg), 32'(want));
    end
    $display("[TB] done data=%b result=%b", d, shreg);
  endtask

  initial begin
    logic [WIDTH-1:0] rd;
    logic             rdir, rfill;
    logic [CW-1:0]    rc;

    clr_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_dir   = 1'b0;
    in_cnt   = '0;
    in_fill  = 1'b0;

    #12;
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_par", 32'(par_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    clr_n = 1'b1;

    // right shift by 2, fill 0: 1010 -> 0010
    issue(4'b1010, 1'b0, 3'd2, 1'b0);
    follow(4'b1010, 1'b0, 3'd2, 1'b0, 1'b0);
    check("result_const_a", 32'(shreg), 32'b0010);
    @(posedge clk);
    #1;
    check("idle_done", 32'(done), 32'd0);
    check("idle_sel", 32'(sel), 32'd0);
    check("idle_par_hold", 32'(par_out), 32'b1010);
    check("idle_ready", 32'(in_ready), 32'd1);

    // left shift by 1, fill 1, with a stray request while busy: 0011 -> 0111
    issue(4'b0011, 1'b1, 3'd1, 1'b1);
    follow(4'b0011, 1'b1, 3'd1, 1'b1, 1'b1);
    check("result_const_b", 32'(shreg), 32'b0111);

    // back-to-back: second command presented in the DONE cycle
    issue(4'b1100, 1'b0, 3'd3, 1'b1);
    follow(4'b1100, 1'b0, 3'd3, 1'b1, 1'b0);
    issue(4'b0101, 1'b1, 3'd2, 1'b0);
    follow(4'b0101, 1'b1, 3'd2, 1'b0, 1'b0);

    // load only, then clamped counts
    issue(4'b1001, 1'b0, 3'd0, 1'b0);
    follow(4'b1001, 1'b0, 3'd0, 1'b0, 1'b0);
    issue(4'b0001, 1'b0, 3'd7, 1'b1);
    follow(4'b0001, 1'b0, 3'd7, 1'b1, 1'b0);
    issue(4'b1000, 1'b1, 3'd5, 1'b0);
    follow(4'b1000, 1'b1, 3'd5, 1'b0, 1'b0);

`ifdef USR_SEQ_ROTATE_EN
    // full rotation returns the original word
    issue(4'b1000, 1'b0, 3'd4, 1'b0);
    follow(4'b1000, 1'b0, 3'd4, 1'b0, 1'b0);
    check("rotate_full", 32'(shreg), 32'b1000);
`endif

    // random back-to-back commands
    for (int k = 0; k < 6; k++) begin
      rd    = 4'($urandom);
      rdir  = 1'($urandom);
      rc    = 3'($urandom);
      rfill = 1'($urandom);
      issue(rd, rdir, rc, rfill);
      follow(rd, rdir, rc, rfill, 1'($urandom));
    end

    // reset in the middle of SHIFT aborts with no late done
    issue(4'b1110, 1'b1, 3'd4, 1'b0);
    @(posedge clk);
    #3;
    clr_n = 1'b0;
    #1;
    check("abort_sel", 32'(sel), 32'd0);
    check("abort_par", 32'(par_out), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd1);
    check("abort_serial", 32'({right_out, left_out}), 32'd0);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    $display("[TB] reset asserted mid-command");
    @(negedge clk);
    clr_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      check("post_abort_done", 32'(done), 32'd0);
      check("post_abort_busy", 32'(busy), 32'd0);
    end

    // normal operation after the abort: 0110 left by 2 fill 1 -> 1011
    issue(4'b0110, 1'b1, 3'd2, 1'b1);
    follow(4'b0110, 1'b1, 3'd2, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
